// File: rtl/reg_dump.sv
// Register-file debug reader: walks the display read port and streams each
// register as four uppercase ASCII hex digits plus a space/newline separator.
module reg_dump #(
  parameter int unsigned LAST_REG = 31,
  parameter int unsigned PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  addr,
  input  logic [15:0] data_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ADDR, SEND} state_t;

  localparam logic [4:0] LAST_IDX = 5'(LAST_REG);
  localparam logic [4:0] LINE_END = 5'(PER_LINE - 1);

  state_t      state;
  logic [4:0]  index;
  logic [4:0]  line_pos;
  logic [15:0] shadow;
  logic [2:0]  byte_cnt;
  logic [7:0]  next_byte;
  logic [7:0]  sep_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
    else             hex_char = 8'h37 + {4'h0, nib};
  endfunction

  // A running position within the text line avoids a modulo on the index.
  assign sep_byte = (line_pos == LINE_END || index == LAST_IDX) ? 8'h0A : 8'h20;

  // Byte presented after byte_cnt has been accepted.
  always_comb begin
    next_byte = sep_byte;
    unique case (byte_cnt)
      3'd0:    next_byte = hex_char(shadow[11:8]);
      3'd1:    next_byte = hex_char(shadow[7:4]);
      3'd2:    next_byte = hex_char(shadow[3:0]);
      default: next_byte = sep_byte;
    endcase
  end

  assign addr = index;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      line_pos <= '0;
      shadow   <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ADDR;
            index    <= '0;
            line_pos <= '0;
            busy     <= 1'b1;
          end
        end
        ADDR: begin
          shadow   <= data_in;
          tx_data  <= hex_char(data_in[15:12]);
          tx_valid <= 1'b1;
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_cnt == 3'd4) begin
              tx_valid <= 1'b0;
              if (index == LAST_IDX) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= ADDR;
                index    <= index + 5'd1;
                line_pos <= (line_pos == LINE_END) ? '0 : line_pos + 5'd1;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              tx_data  <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
